// File: rtl/mips_pkg.sv
// Shared widths and Tuse/Tnew constants for the MIPS pipeline hazard logic.
package mips_pkg;

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned TW   = 2;
  localparam int unsigned CW   = 2;

  typedef logic [TW-1:0] tcyc_t;
  typedef logic [CW-1:0] wcnt_t;
  typedef logic [AW-1:0] raddr_t;

  // Largest representable in-flight writer count; a further issue must stall.
  localparam wcnt_t INFL_MAX = CW'((1 << CW) - 1);

  localparam tcyc_t ALU_TNEW      = TW'(1);
  localparam tcyc_t LOAD_TNEW     = TW'(2);
  localparam tcyc_t BR_TUSE       = TW'(0);
  localparam tcyc_t ALU_TUSE      = TW'(1);
  localparam tcyc_t STORE_RT_TUSE = TW'(2);

endpackage

// File: rtl/sb_entry.sv
// One scoreboard register: in-flight writer count plus the youngest writer's remaining Tnew.
module sb_entry
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_i,
  input  logic          ret_i,
  input  logic [TW-1:0] tnew_i,
  output logic [CW-1:0] inflight_o,
  output logic [TW-1:0] cnt_o,
  output logic          ret_err_o
);

  wcnt_t inflight_q, inflight_d;
  tcyc_t cnt_q, cnt_d;

  // Next state: countdown, then retire, then issue (issue overrides the count).
  always_comb begin
    inflight_d = inflight_q;
    cnt_d      = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
    if (ret_i && !iss_i && inflight_q != '0) begin
      inflight_d = inflight_q - CW'(1);
      if (inflight_q == CW'(1)) begin
        cnt_d = '0;
      end
    end
    if (iss_i) begin
      cnt_d = tnew_i;
      if (!ret_i) begin
        inflight_d = inflight_q + CW'(1);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  assign inflight_o = inflight_q;
  assign cnt_o      = cnt_q;
  assign ret_err_o  = ret_i && (inflight_q == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// D-stage hazard scoreboard: tracks in-flight GRF writes and stalls reads that forwarding cannot serve yet.
module reg_scoreboard
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          iss_valid,
  input  logic [4:0]    iss_rs,
  input  logic [TW-1:0] iss_rs_tuse,
  input  logic          iss_rs_use,
  input  logic [4:0]    iss_rt,
  input  logic [TW-1:0] iss_rt_tuse,
  input  logic          iss_rt_use,
  input  logic [4:0]    iss_dst,
  input  logic [TW-1:0] iss_tnew,
  input  logic          wb_we,
  input  logic [4:0]    wb_addr,
  output logic          stall,
  output logic          rs_pend,
  output logic          rt_pend,
  output logic          err
);

  logic [NREG-1:0][CW-1:0] infl;
  logic [NREG-1:0][TW-1:0] cnt;
  logic [NREG-1:0]         ret_err;
  logic                    haz_rs, haz_rt, full_dst, issue;
  logic                    err_q;

  // $0 is hard-wired untracked.
  assign infl[0]    = '0;
  assign cnt[0]     = '0;
  assign ret_err[0] = 1'b0;

  assign issue = iss_valid && !stall && (iss_dst != '0);

  // One tracking entry per writable register.
  for (genvar r = 1; r < NREG; r++) begin : g_ent
    sb_entry u_ent (
      .clk        (clk),
      .rst        (rst),
      .iss_i      (issue && (iss_dst == AW'(r))),
      .ret_i      (wb_we && (wb_addr == AW'(r))),
      .tnew_i     (iss_tnew),
      .inflight_o (infl[r]),
      .cnt_o      (cnt[r]),
      .ret_err_o  (ret_err[r])
    );
  end

  // Read-side compare: pending writers and whether their result arrives too late.
  always_comb begin
    rs_pend  = iss_valid && (iss_rs != '0) && (infl[iss_rs] != '0);
    rt_pend  = iss_valid && (iss_rt != '0) && (infl[iss_rt] != '0);
    haz_rs   = rs_pend && iss_rs_use && (cnt[iss_rs] > iss_rs_tuse);
    haz_rt   = rt_pend && iss_rt_use && (cnt[iss_rt] > iss_rt_tuse);
    full_dst = iss_valid && (iss_dst != '0) && (infl[iss_dst] == INFL_MAX);
    stall    = haz_rs || haz_rt || full_dst;
  end

  // Sticky error on retiring a register with no writer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (|ret_err) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazard scenarios with hand-derived stall/pend/err values.
module tb_reg_scoreboard;
  import mips_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          iss_valid;
  logic [4:0]    iss_rs, iss_rt, iss_dst, wb_addr;
  logic [TW-1:0] iss_rs_tuse, iss_rt_tuse, iss_tnew;
  logic          iss_rs_use, iss_rt_use, wb_we;
  logic          stall, rs_pend, rt_pend, err;

  int n_chk = 0;
  int n_err = 0;

  reg_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .iss_valid   (iss_valid),
    .iss_rs      (iss_rs),
    .iss_rs_tuse (iss_rs_tuse),
    .iss_rs_use  (iss_rs_use),
    .iss_rt      (iss_rt),
    .iss_rt_tuse (iss_rt_tuse),
    .iss_rt_use  (iss_rt_use),
    .iss_dst     (iss_dst),
    .iss_tnew    (iss_tnew),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .stall       (stall),
    .rs_pend     (rs_pend),
    .rt_pend     (rt_pend),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [TW-1:0] rs_t,
                       input logic rs_u, input logic [4:0] rt, input logic [TW-1:0] rt_t,
                       input logic rt_u, input logic [4:0] dst, input logic [TW-1:0] tnew);
    iss_valid   = v;
    iss_rs      = rs;
    iss_rs_tuse = rs_t;
    iss_rs_use  = rs_u;
    iss_rt      = rt;
    iss_rt_tuse = rt_t;
    iss_rt_use  = rt_u;
    iss_dst     = dst;
    iss_tnew    = tnew;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
  endtask

  task automatic wb(input logic we, input logic [4:0] a);
    wb_we   = we;
    wb_addr = a;
    #1;
  endtask

  task automatic do_reset();
    idle();
    wb(1'b0, 5'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    wb(1'b0, 5'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_rs_pend", rs_pend, 1'b0);
    chk("rst_rt_pend", rt_pend, 1'b0);
    chk("rst_err", err, 1'b0);

    // Load-use: lw $8 then add rs=$8 (tuse 1) stalls exactly one cycle.
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd8, LOAD_TNEW);
    chk("lu_lw_nostall", stall, 1'b0);
    tick();
    drive(1'b1, 5'd8, ALU_TUSE, 1'b1, 5'd0, 2'd0, 1'b0, 5'd10, ALU_TNEW);
    chk("lu_stall1", stall, 1'b1);
    chk("lu_pend1", rs_pend, 1'b1);
    tick();
    chk("lu_stall2", stall, 1'b0);
    chk("lu_pend2", rs_pend, 1'b1);
    tick();
    drive(1'b0, 5'd8, 2'd0, 1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    chk("novalid_stall", stall, 1'b0);
    chk("novalid_pend", rs_pend, 1'b0);

    // ALU-branch back to back, then with a one-cycle gap.
    do_reset();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd5, ALU_TNEW);
    tick();
    drive(1'b1, 5'd5, BR_TUSE, 1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    chk("br_stall1", stall, 1'b1);
    tick();
    chk("br_stall2", stall, 1'b0);
    do_reset();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd5, ALU_TNEW);
    tick();
    idle();
    tick();
    drive(1'b1, 5'd5, BR_TUSE, 1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    chk("br_sep_stall", stall, 1'b0);
    chk("br_sep_pend", rs_pend, 1'b1);

    // $0 as destination and source; retire to $0 is not an error.
    do_reset();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, LOAD_TNEW);
    chk("z_lw_stall", stall, 1'b0);
    tick();
    drive(1'b1, 5'd0, 2'd0, 1'b1, 5'd0, 2'd0, 1'b1, 5'd0, 2'd0);
    chk("z_stall", stall, 1'b0);
    chk("z_rs_pend", rs_pend, 1'b0);
    chk("z_rt_pend", rt_pend, 1'b0);
    idle();
    wb(1'b1, 5'd0);
    tick();
    wb(1'b0, 5'd0);
    chk("z_wb_err", err, 1'b0);

    // Write-after-write on $3: two writers, two retires.
    do_reset();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd3, LOAD_TNEW);
    tick();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd3, ALU_TNEW);
    chk("waw_issue2", stall, 1'b0);
    tick();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd3, BR_TUSE, 1'b1, 5'd0, 2'd0);
    chk("waw_stall", stall, 1'b1);
    chk("waw_pend", rt_pend, 1'b1);
    wb(1'b1, 5'd3);
    tick();
    wb(1'b0, 5'd0);
    chk("waw_ret1_pend", rt_pend, 1'b1);
    chk("waw_ret1_stall", stall, 1'b0);
    wb(1'b1, 5'd3);
    tick();
    wb(1'b0, 5'd0);
    chk("waw_ret2_pend", rt_pend, 1'b0);
    chk("waw_err", err, 1'b0);

    // Three writers saturate the counter; a fourth must stall until one retires.
    do_reset();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd20, 2'd0);
    tick();
    tick();
    tick();
    chk("sat_stall", stall, 1'b1);
    idle();
    wb(1'b1, 5'd20);
    tick();
    wb(1'b0, 5'd0);
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd20, 2'd0);
    chk("sat_release", stall, 1'b0);

    // Simultaneous issue and retire on $9: count stays 1, cnt reloads to 2.
    do_reset();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd9, 2'd0);
    tick();
    wb(1'b1, 5'd9);
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd9, LOAD_TNEW);
    chk("sim_nostall", stall, 1'b0);
    tick();
    wb(1'b0, 5'd0);
    drive(1'b1, 5'd9, ALU_TUSE, 1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    chk("sim_pend", rs_pend, 1'b1);
    chk("sim_stall1", stall, 1'b1);
    tick();
    chk("sim_stall2", stall, 1'b0);
    idle();
    wb(1'b1, 5'd9);
    tick();
    wb(1'b0, 5'd0);
    drive(1'b1, 5'd9, ALU_TUSE, 1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0);
    chk("sim_retired", rs_pend, 1'b0);
    chk("sim_err", err, 1'b0);

    // Retire with nothing in flight: sticky err, cleared only by rst.
    do_reset();
    drive(1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd8, LOAD_TNEW);
    tick();
    idle();
    wb(1'b1, 5'd12);
    tick();
    wb(1'b0, 5'd0);
    chk("err_set", err, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("err_hold", err, 1'b1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 5'd8, BR_TUSE, 1'b1, 5'd8, BR_TUSE, 1'b1, 5'd0, 2'd0);
    chk("rst2_err", err, 1'b0);
    chk("rst2_rs_pend", rs_pend, 1'b0);
    chk("rst2_rt_pend", rt_pend, 1'b0);
    chk("rst2_stall", stall, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
